// File: rtl/servo_ramp_sequencer.sv
// Servo ramp sequencer: takes per-joint targets and steps each joint toward them once per frame.
// Optional build macro SERVO_SEQ_HALT_EN adds a 'halt' input that freezes ramping while high.
module servo_ramp_sequencer #(
  parameter int N_JOINTS    = 4,
  parameter int TICK_CYCLES = 1_000_000,
  parameter int STEP        = 1,
  parameter int POS_MAX     = 100,
  parameter int POS_HOME    = 25
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SERVO_SEQ_HALT_EN
  input  logic                  halt,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_joint,
  input  logic [7:0]            cmd_pos,
  output logic                  cmd_err,
  output logic [8*N_JOINTS-1:0] pos_out,
  output logic [N_JOINTS-1:0]   en_out,
  output logic                  busy,
  output logic                  done
);

  localparam int              CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TICK_CYCLES - 1);
  localparam logic [7:0]      POS_MAX_B = 8'(POS_MAX);
  localparam logic [7:0]      HOME_B    = 8'(POS_HOME);
  localparam logic [8:0]      STEP_B    = 9'(STEP);
  localparam logic [2:0]      LAST_IDX  = 3'(N_JOINTS - 1);
  localparam logic [3:0]      NJ_B      = 4'(N_JOINTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FIN
  } state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        moved_q, moved_d;
  logic [N_JOINTS-1:0][7:0]    cur_q, cur_d;
  logic [N_JOINTS-1:0][7:0]    tgt_q, tgt_d;
  logic [N_JOINTS-1:0]         en_q, en_d;
  logic                        cmd_err_q, cmd_err_d;
  logic                        done_q, done_d;

  logic                        tick;
  logic                        tick_go;
  logic                        accept;

  // Differences are taken in 9 bits so the move never wraps past 0 or 255.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] gap;
    logic [8:0] moved_pos;
    if (tgt >= cur) begin
      gap       = {1'b0, tgt} - {1'b0, cur};
      moved_pos = {1'b0, cur} + STEP_B;
    end else begin
      gap       = {1'b0, cur} - {1'b0, tgt};
      moved_pos = {1'b0, cur} - STEP_B;
    end
    if (gap <= STEP_B) begin
      ramp_step = tgt;
    end else begin
      ramp_step = moved_pos[7:0];
    end
  endfunction

  assign tick = (cnt_q == CNT_LAST);

`ifdef SERVO_SEQ_HALT_EN
  assign tick_go = tick && !halt;
`else
  assign tick_go = tick;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    busy = 1'b0;
    for (int j = 0; j < N_JOINTS; j++) begin
      if (cur_q[j] != tgt_q[j]) begin
        busy = 1'b1;
      end
    end
  end

  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    moved_d   = moved_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    en_d      = en_q;
    cmd_err_d = 1'b0;
    done_d    = 1'b0;

    // Out-of-range positions are clamped but still flagged.
    if (accept) begin
      if ({1'b0, cmd_joint} >= NJ_B) begin
        cmd_err_d = 1'b1;
      end else begin
        cmd_err_d = (cmd_pos > POS_MAX_B);
        for (int j = 0; j < N_JOINTS; j++) begin
          if (cmd_joint == 3'(j)) begin
            tgt_d[j] = (cmd_pos > POS_MAX_B) ? POS_MAX_B : cmd_pos;
            en_d[j]  = 1'b1;
          end
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (tick_go) begin
          state_d = S_SCAN;
          idx_d   = '0;
          moved_d = 1'b0;
        end
      end
      S_SCAN: begin
        for (int j = 0; j < N_JOINTS; j++) begin
          if (idx_q == 3'(j)) begin
            cur_d[j] = ramp_step(cur_q[j], tgt_q[j]);
            if (cur_d[j] != cur_q[j]) begin
              moved_d = 1'b1;
            end
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_FIN: begin
        done_d  = moved_q && !busy;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      moved_q   <= 1'b0;
      cur_q     <= {N_JOINTS{HOME_B}};
      tgt_q     <= {N_JOINTS{HOME_B}};
      en_q      <= '0;
      cmd_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      moved_q   <= moved_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      en_q      <= en_d;
      cmd_err_q <= cmd_err_d;
      done_q    <= done_d;
    end
  end

  assign pos_out = cur_q;
  assign en_out  = en_q;
  assign cmd_err = cmd_err_q;
  assign done    = done_q;

endmodule
